rgb_pwm_fader: RTL
==================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter PRESCALE, default 188, meaning clk cycles per PWM count step (48 MHz / 188 / 256 gives about 1 kHz PWM); legal range 1..65535.
REQ-002 Parameter FADE_DIV, default 4, meaning PWM periods per fade step; legal range 1..255.
REQ-003 clk  input  1  system clock, 48 MHz global-buffered; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-005 tgt_r / tgt_g / tgt_b  input  8 each  target duty per channel (0 = off, 255 = 255/256 on).
REQ-006 tgt_valid  input  1  the target triple is valid.
REQ-007 tgt_ready  output  1  the block accepts a target this cycle.
REQ-008 led_r / led_g / led_b  output  1 each  registered PWM, driving the LED driver PWM inputs (red, green, blue).
REQ-009 busy  output  1  a fade is in progress.

Function
REQ-010 Prescaler counts 0..PRESCALE-1 and wraps; the "tick" is the cycle in which it equals PRESCALE-1.
REQ-011 PWM counter is 8 bits, increments on each tick, and wraps 255->0; the "boundary" is the tick on which it wraps.
REQ-012 Each led_x is registered as (pwm_cnt < cur_x); the output lags pwm_cnt by 1 clk; cur_x = 0 gives constant low.
REQ-013 The cur_x duty registers change only on a boundary, so no PWM period ever sees a mid-period duty change.
REQ-014 Fade counter counts boundaries 0..FADE_DIV-1 and wraps; the "step instant" is the boundary on which it wraps.
REQ-015 At each step instant in FADE, every cur_x moves 1 toward its tgt_x (+1 if below, -1 if above, unchanged if equal); no overshoot and no wrap-around.
REQ-016 FSM states: IDLE, FADE; tgt_ready = (state == IDLE); busy = (state == FADE).
REQ-017 IDLE->FADE when tgt_valid & tgt_ready; targets are captured into internal tgt registers in the same cycle.
REQ-018 FADE->IDLE at the step instant where all three cur_x equal tgt_x after the update; a target equal to the current duties is accepted and leaves at the next step instant.
REQ-019 While in FADE, tgt_valid is ignored; the source holds its data until tgt_ready is high; no queueing.
REQ-020 The prescaler, PWM counter and fade counter free-run in both states; fade timing is not aligned to acceptance.
REQ-021 Channels are independent: a channel that reaches its target holds while the others continue.

Reset
REQ-022 Reset state while rst_n = 0: all counters 0, cur_x = 0, tgt registers 0, state IDLE.
REQ-023 Output values in reset: led_x = 0, busy = 0, tgt_ready = 1.
REQ-024 Reset asserted mid-fade aborts the fade; the LEDs go dark on the same edge; the prior target is lost.
REQ-025 Release is synchronous to clk; the first tick follows PRESCALE cycles after deassertion.

Structure
REQ-026 Shared package rgb_pwm_pkg holds the state enum (IDLE, FADE), DUTY_W = 8, and the PWM period constant 256.
REQ-027 Sub-module rgb_pwm_channel holds the duty register, step-toward-target logic and compare/output register; it is instantiated three times, with its step enable and boundary strobes from the top.
REQ-028 Prescaler, PWM counter, fade counter and FSM live in the top; every output is driven from a flop.

Verification (PRESCALE=2, FADE_DIV=1 unless stated; PWM period = 512 clk)
REQ-029 Reset release -> led_* = 0, tgt_ready = 1, busy = 0; all stay low for 4 periods with no target.
REQ-030 Target (4,0,0) accepted -> busy high for exactly 4 step instants; cur_r ends at 4; led_r high 8 clk per period (4 counts x 2); green and blue stay 0.
REQ-031 Target (255,0,255) from (0,0,0) with FADE_DIV=2 -> 510 periods to IDLE; led_b low only for pwm_cnt = 255.
REQ-032 Fade down (10,10,10)->(7,10,12) -> r falls and b rises over 3 steps, g is constant, busy drops after the 3rd step.
REQ-033 tgt_valid pulsed with (50,50,50) during FADE -> ignored; the final duties equal the earlier target; acceptance happens only when tgt_ready = 1.
REQ-034 rst_n low mid-fade at cur_r = 20 -> led_* = 0 and cur = 0 on the same edge; tgt_ready = 1 after release.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM fader.
package rgb_pwm_pkg;

    localparam int DUTY_W     = 8;
    localparam int PWM_PERIOD = 256;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One colour channel: duty register stepping toward its target, PWM compare
// and registered LED output.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] i_tgt,
    input  logic [DUTY_W-1:0] i_pwm_cnt,
    input  logic              i_boundary,
    input  logic              i_step_en,
    output logic              o_led,
    output logic              o_done_next
);

    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              r_led;

    // Move one count toward the target; saturating by construction.
    always_comb begin
        w_duty_nxt = r_duty;
        if (r_duty < i_tgt) begin
            w_duty_nxt = r_duty + 1'b1;
        end else if (r_duty > i_tgt) begin
            w_duty_nxt = r_duty - 1'b1;
        end
    end

    // Duty only changes on a period boundary so every period sees one duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
        end else if (i_boundary && i_step_en) begin
            r_duty <= w_duty_nxt;
        end
    end

    // Registered compare; output lags the PWM counter by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (i_pwm_cnt < r_duty);
        end
    end

    assign o_led       = r_led;
    assign o_done_next = (w_duty_nxt == i_tgt);

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader: prescaler, PWM counter, fade-step counter and the
// IDLE/FADE handshake FSM driving three duty-stepping channels.
//
// state | meaning
// IDLE  | duties steady, ready to accept a new target triple
// FADE  | duties step by one toward the target at every step instant
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE = 188,
    parameter int FADE_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] tgt_r,
    input  logic [DUTY_W-1:0] tgt_g,
    input  logic [DUTY_W-1:0] tgt_b,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              busy
);

    localparam int PRE_W  = 16;
    localparam int FADE_W = 8;

    logic [PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0] r_pwm;
    logic [FADE_W-1:0] r_fade;
    logic [DUTY_W-1:0] r_tgt_r;
    logic [DUTY_W-1:0] r_tgt_g;
    logic [DUTY_W-1:0] r_tgt_b;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready;
    logic              r_busy;

    logic w_tick;
    logic w_boundary;
    logic w_fade_wrap;
    logic w_step_en;
    logic w_accept;
    logic w_done_r;
    logic w_done_g;
    logic w_done_b;

    assign w_tick      = (r_pre == PRE_W'(PRESCALE - 1));
    assign w_boundary  = w_tick && (r_pwm == DUTY_W'(PWM_PERIOD - 1));
    assign w_fade_wrap = (r_fade == FADE_W'(FADE_DIV - 1));
    assign w_step_en   = w_fade_wrap && (r_state == FADE);
    assign w_accept    = tgt_valid && (r_state == IDLE);

    // Free-running prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // 8-bit PWM counter, natural wrap 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else if (w_tick) begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Counts PWM boundaries; its wrap marks a fade step instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fade <= '0;
        end else if (w_boundary) begin
            r_fade <= w_fade_wrap ? '0 : r_fade + 1'b1;
        end
    end

    // Target capture on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt_r <= '0;
            r_tgt_g <= '0;
            r_tgt_b <= '0;
        end else if (w_accept) begin
            r_tgt_r <= tgt_r;
            r_tgt_g <= tgt_g;
            r_tgt_b <= tgt_b;
        end
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt == FADE);
        end
    end

    // Next-state: leave FADE on the step instant that lands all channels.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (tgt_valid) begin
                    w_state_nxt = FADE;
                end
            end
            FADE: begin
                if (w_boundary && w_step_en && w_done_r && w_done_g && w_done_b) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    rgb_pwm_channel u_ch_r (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tgt       (r_tgt_r),
        .i_pwm_cnt   (r_pwm),
        .i_boundary  (w_boundary),
        .i_step_en   (w_step_en),
        .o_led       (led_r),
        .o_done_next (w_done_r)
    );

    rgb_pwm_channel u_ch_g (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tgt       (r_tgt_g),
        .i_pwm_cnt   (r_pwm),
        .i_boundary  (w_boundary),
        .i_step_en   (w_step_en),
        .o_led       (led_g),
        .o_done_next (w_done_g)
    );

    rgb_pwm_channel u_ch_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tgt       (r_tgt_b),
        .i_pwm_cnt   (r_pwm),
        .i_boundary  (w_boundary),
        .i_step_en   (w_step_en),
        .o_led       (led_b),
        .o_done_next (w_done_b)
    );

    assign tgt_ready = r_ready;
    assign busy      = r_busy;

endmodule
